sram_model: RTL and testbench

Clocked behavioural model of an asynchronous-interface byte-wide static RAM with active-low chip-enable, write-enable and output-enable strobes. Two instances side by side form a 16-bit memory on the expansion bus: low byte on `d[7:0]` and high byte on `d[15:8]` of the system data bus, both sharing the address and strobes. The storage array is directly addressable from the bench so memory images can be preloaded with `$readmemb`.

---
 rtl/sram_model_pkg.sv | 15 +
 rtl/sram_model_acc_timer.sv | 100 ++++++++++
 rtl/sram_model.sv | 80 ++++++++
 tb/tb_sram_model.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_model_pkg.sv
// Shared types and constants for the byte-wide SRAM model and its access timer.
package sram_model_pkg;

    localparam int SRAM_MODEL_DATA_W = 8;
    localparam int ACC_CYC_MIN       = 1;
    localparam int ACC_CYC_MAX       = 255;
    localparam int ACC_CNT_W         = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        VALID
    } acc_state_e;

endpackage

// File: rtl/sram_model_acc_timer.sv
// Read access timer: counts consecutive read-cycle edges on a stable address.
// Exposes an extra access_o port when SRAM_MODEL_XCHECK_EN is defined.
module sram_model_acc_timer
    import sram_model_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int ACC_CYC = 55
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              read_cyc_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              valid_o,
    output logic              load_o,
    output logic              restart_o
`ifdef SRAM_MODEL_XCHECK_EN
    ,
    output logic              access_o
`endif
);

    localparam logic [ACC_CNT_W-1:0] ACC_LAST = ACC_CNT_W'(ACC_CYC);

    if (ACC_CYC < ACC_CYC_MIN || ACC_CYC > ACC_CYC_MAX) begin : g_bad_acc_cyc
        $error("sram_model_acc_timer: ACC_CYC out of range");
    end

    acc_state_e           state_q, state_d;
    logic [ACC_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 start;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        start     = 1'b0;
        load_o    = 1'b0;
        restart_o = 1'b0;
        if (!read_cyc_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE:   start = 1'b1;
                ACCESS: begin
                    if (addr_i != addr_q) begin
                        start     = 1'b1;
                        restart_o = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_d == ACC_LAST) begin
                            state_d = VALID;
                            load_o  = 1'b1;
                        end
                    end
                end
                VALID: begin
                    // Output register follows the address every edge while valid.
                    load_o = 1'b1;
                    if (addr_i != addr_q) begin
                        start     = 1'b1;
                        restart_o = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (start) begin
                cnt_d  = 1;
                addr_d = addr_i;
                if (ACC_LAST == 1) begin
                    state_d = VALID;
                    load_o  = 1'b1;
                end else begin
                    state_d = ACCESS;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    assign valid_o = (state_q == VALID);
`ifdef SRAM_MODEL_XCHECK_EN
    assign access_o = (state_q == ACCESS);
`endif

endmodule

// File: rtl/sram_model.sv
// Clocked model of a byte-wide async SRAM with active-low CE/WE/OE strobes.
// Define SRAM_MODEL_XCHECK_EN to drive X before access time and flag X/Z writes.
module sram_model
    import sram_model_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int ACC_CYC = 55
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic [ADDR_W-1:0]            a,
    inout  wire  [SRAM_MODEL_DATA_W-1:0] d,
    input  logic                         nce,
    input  logic                         nwe,
    input  logic                         noe
);

    logic [SRAM_MODEL_DATA_W-1:0] mem [0:2**ADDR_W-1];
    logic [SRAM_MODEL_DATA_W-1:0] dout_q;
    logic write_cyc, read_cyc;
    logic valid, load, restart;

    assign write_cyc = !nce && !nwe;
    assign read_cyc  = !nce && !noe && nwe;

`ifdef SRAM_MODEL_XCHECK_EN
    logic access;
`endif

    sram_model_acc_timer #(
        .ADDR_W  (ADDR_W),
        .ACC_CYC (ACC_CYC)
    ) u_acc_timer (
        .clk        (clk),
        .nreset     (nreset),
        .read_cyc_i (read_cyc),
        .addr_i     (a),
        .valid_o    (valid),
        .load_o     (load),
        .restart_o  (restart)
`ifdef SRAM_MODEL_XCHECK_EN
        ,
        .access_o   (access)
`endif
    );

    // NOTE: the array has no reset so images survive nreset and preloads stick.
    always_ff @(posedge clk) begin
        if (write_cyc) begin
            mem[a] <= d;
        end
    end

`ifdef SRAM_MODEL_XCHECK_EN
    always_ff @(posedge clk) begin
        if (write_cyc) begin
            assert (!$isunknown({a, d}))
            else $error("ERROR: write with X/Z at time %0t addr %h", $time, a);
        end
    end
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            dout_q <= '0;
        end else if (load || restart) begin
            dout_q <= mem[a];
        end
    end

    // Drive decision is combinational so releasing a strobe frees the bus at once.
`ifdef SRAM_MODEL_XCHECK_EN
    assign d = (valid && read_cyc)  ? dout_q :
               (access && read_cyc) ? {SRAM_MODEL_DATA_W{1'bx}} :
                                      {SRAM_MODEL_DATA_W{1'bz}};
`else
    assign d = (valid && read_cyc) ? dout_q : {SRAM_MODEL_DATA_W{1'bz}};
`endif

endmodule

// File: tb/tb_sram_model.sv
// Directed plus randomized bench for sram_model with ACC_CYC=3 and a pulled-up data bus.
module tb_sram_model;

    localparam int          ADDR_W   = 16;
    localparam int          ACC      = 3;
    localparam logic [7:0]  BUS_IDLE = 8'hFF;  // released bus floats to the pull-up level

    logic        clk = 1'b0;
    logic        nreset;
    logic [15:0] a;
    logic        nce, nwe, noe;
    logic        tb_oe;
    logic [7:0]  tb_dout;
    tri1  [7:0]  d;

    assign d = tb_oe ? tb_dout : 8'hzz;

    always #5 clk = ~clk;

    sram_model #(
        .ADDR_W  (ADDR_W),
        .ACC_CYC (ACC)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .a      (a),
        .d      (d),
        .nce    (nce),
        .nwe    (nwe),
        .noe    (noe)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model_mem [int];
    int          run   = 0;       // consecutive read edges on the current address
    logic [15:0] run_a = '0;
    logic [15:0] pool [8] = '{16'h0000, 16'hFFFF, 16'h1234, 16'h0100,
                              16'h0200, 16'h0201, 16'h0300, 16'h0301};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected bus value: data once the address has been read for ACC edges and strobes are held.
    function automatic logic [7:0] exp_d();
        if (!nce && !noe && nwe && run >= ACC) return model_mem[int'(a)];
        return BUS_IDLE;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!nce && !nwe) begin
            model_mem[int'(a)] = tb_dout;
            run = 0;
        end else if (!nce && !noe) begin
            if (run > 0 && a == run_a) run = (run < ACC) ? run + 1 : run;
            else run = 1;
            run_a = a;
        end else begin
            run = 0;
        end
        #1;
    endtask

    task automatic deselect();
        nce = 1'b1; nwe = 1'b1; noe = 1'b1; tb_oe = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
        a = addr; tb_dout = data; tb_oe = 1'b1;
        nce = 1'b0; nwe = 1'b0; noe = 1'b1;
        tick();
        deselect();
    endtask

    task automatic start_read(input logic [15:0] addr);
        a = addr; tb_oe = 1'b0;
        nce = 1'b0; nwe = 1'b1; noe = 1'b0;
    endtask

    task automatic read_edges(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check(tag, d, exp_d());
        end
    endtask

    initial begin
        deselect();
        a = '0; tb_dout = '0;
        nreset = 1'b0;
        start_read(16'h1234);
        #12;
        check("reset_bus", d, BUS_IDLE);
        check("reset_dout", dut.dout_q, 8'h00);
        @(negedge clk);
        nreset = 1'b1;
        deselect();
        tick();

        // Basic write then read with latency ACC
        do_write(16'h1234, 8'hA5);
        start_read(16'h1234);
        #1;
        check("rd_pre_edge", d, BUS_IDLE);
        tick(); check("rd_edge1", d, BUS_IDLE);
        tick(); check("rd_edge2", d, BUS_IDLE);
        tick(); check("rd_edge3", d, 8'hA5);
        noe = 1'b1; #1;
        check("oe_release", d, BUS_IDLE);
        deselect(); tick();

        // Boundary addresses
        do_write(16'h0000, 8'h01);
        do_write(16'hFFFF, 8'hFE);
        start_read(16'h0000);  read_edges("rd_addr0", ACC);
        check("rd_addr0_val", d, 8'h01);
        start_read(16'hFFFF);  read_edges("rd_addr_top", ACC);
        check("rd_addr_top_val", d, 8'hFE);
        start_read(16'h1234);  read_edges("rd_other", ACC + 1);
        check("rd_other_val", d, 8'hA5);
        deselect(); tick();

        // Write priority with both strobes low
        a = 16'h0100; tb_dout = 8'h3C; tb_oe = 1'b1;
        nce = 1'b0; nwe = 1'b0; noe = 1'b0;
        #1; check("wp_bus_pre", d, 8'h3C);
        for (int i = 0; i < ACC + 1; i++) begin
            tick(); check("wp_bus", d, 8'h3C);
        end
        check("wp_mem", dut.mem[16'h0100], 8'h3C);
        deselect(); tick();

        // Address change at count 2 restarts the access
        do_write(16'h0200, 8'h5A);
        do_write(16'h0201, 8'hC3);
        start_read(16'h0200);
        read_edges("ac_before", 2);
        a = 16'h0201;
        tick(); check("ac_edge1", d, BUS_IDLE);
        tick(); check("ac_edge2", d, BUS_IDLE);
        tick(); check("ac_edge3", d, 8'hC3);

        // Async reset while valid: bus released without a clock edge
        start_read(16'h1234);
        read_edges("rst_prep", ACC);
        check("rst_prep_val", d, 8'hA5);
        nreset = 1'b0; run = 0;
        #1; check("rst_async_bus", d, BUS_IDLE);
        #1; nreset = 1'b1;
        read_edges("rst_after", ACC);
        check("rst_after_val", d, 8'hA5);
        deselect(); tick();

        // Preloaded image written straight into the array through the hierarchy
        dut.mem[16'h0000] = 8'h96;
        dut.mem[16'hFFFF] = 8'h69;
        model_mem[16'h0000] = 8'h96;
        model_mem[16'hFFFF] = 8'h69;
        start_read(16'h0000); read_edges("pre_lo", ACC);
        check("pre_lo_val", d, 8'h96);
        check("pre_lo_known", {7'b0, $isunknown(d)}, 8'h00);
        start_read(16'hFFFF); read_edges("pre_hi", ACC);
        check("pre_hi_val", d, 8'h69);
        check("pre_hi_known", {7'b0, $isunknown(d)}, 8'h00);
        deselect(); tick();

        // Randomized traffic over a small pre-written address pool
        do_write(16'h0300, 8'($urandom));
        do_write(16'h0301, 8'($urandom));
        for (int it = 0; it < 40; it++) begin
            int op;
            op = $urandom_range(0, 3);
            if (op == 0) begin
                do_write(pool[$urandom_range(0, 7)], 8'($urandom));
            end else begin
                start_read(pool[$urandom_range(0, 7)]);
                for (int e = 0; e < $urandom_range(1, 6); e++) begin
                    if (op == 3 && $urandom_range(0, 2) == 0) a = pool[$urandom_range(0, 7)];
                    tick();
                    check("rnd_read", d, exp_d());
                end
                if ($urandom_range(0, 1) == 1) begin
                    noe = 1'b1; #1;
                    check("rnd_release", d, BUS_IDLE);
                end
                deselect();
                tick();
                check("rnd_idle", d, BUS_IDLE);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
